// File: rtl/fp_pack.sv
// fp_pack: back end of the single-precision adder.
// Takes sign, widened biased exponent and an unnormalized 27-bit mantissa sum,
// normalizes one bit per cycle, rounds to nearest-even and packs the IEEE-754 word.
//
// Handshake: a transfer happens on the rising edge where valid & ready are both
// high; valid is never withdrawn before that edge, and ready/valid here are
// decoded purely from the registered state (in_ready in IDLE, out_valid in DONE).
module fp_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [26:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  // Kept as a named enum so checkers can bind to fp_pack.state directly.
  state_t             state;
  logic               sign_q;
  logic signed [10:0] exp_q;
  logic [26:0]        mant_q;
  logic               zero_q;

  logic               round_up;
  logic [24:0]        rnd;
  logic [22:0]        frac;
  logic signed [10:0] exp_rnd;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Round-to-nearest-even on the normalized mantissa; a carry out of the hidden
  // bit renormalizes by one (the fraction is then all zeros).
  always_comb begin
    round_up = mant_q[1] & (mant_q[0] | mant_q[2]);
    rnd      = mant_q[26:2] + {24'd0, round_up};
    frac     = rnd[22:0];
    exp_rnd  = exp_q;
    if (rnd[24]) begin
      frac    = rnd[23:1];
      exp_rnd = exp_q + 11'sd1;
    end
  end

  // Control FSM plus datapath registers: latch, normalize, round/classify, hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign_q        <= 1'b0;
      exp_q         <= 11'sd0;
      mant_q        <= 27'd0;
      zero_q        <= 1'b0;
      out_result    <= 32'h0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= {in_exp[9], in_exp};
            mant_q <= in_mant;
            zero_q <= 1'b0;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mant_q == 27'd0) begin
            zero_q <= 1'b1;
            state  <= ROUND;
          end else if (mant_q[26]) begin
            // Carry: shift right, keep the dropped bit alive in sticky.
            mant_q <= {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + 11'sd1;
            state  <= ROUND;
          end else if (mant_q[25]) begin
            state <= ROUND;
          end else begin
            mant_q <= {mant_q[25:0], 1'b0};
            exp_q  <= exp_q - 11'sd1;
          end
        end
        ROUND: begin
          out_overflow  <= 1'b0;
          out_underflow <= 1'b0;
          if (zero_q) begin
            out_result <= {sign_q, 31'd0};
          end else if (exp_rnd >= 11'sd255) begin
            out_result   <= {sign_q, 8'hFF, 23'd0};
            out_overflow <= 1'b1;
          end else if (exp_rnd <= 11'sd0) begin
            // No denormals: anything below the normal range flushes to zero.
            out_result    <= {sign_q, 31'd0};
            out_underflow <= 1'b1;
          end else begin
            out_result <= {sign_q, exp_rnd[7:0], frac};
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_pack.md
# fp_pack

Sequential result packer for the single-precision FP adder datapath; it performs the inverse of the operand partitioning stage. It accepts a sign, a widened biased exponent and an unnormalized mantissa sum with guard bits, then normalizes one bit per cycle, rounds to nearest-even and assembles the IEEE-754 32-bit word. It sits at the adder back end, between the mantissa add/subtract stage and the result consumer, with valid/ready handshakes on both sides.

## Interface
- No parameters; field widths are fixed at IEEE-754 single precision (1/8/23).
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input word valid
- in_ready  output  1  packer can accept; high only in IDLE
- in_sign  input  1  result sign
- in_exp  input  10  signed two's-complement biased exponent of bit 25 of in_mant
- in_mant  input  27  [26] carry, [25] hidden, [24:2] fraction, [1] round, [0] sticky
- out_valid  output  1  out_result valid
- out_ready  input  1  consumer accepts
- out_result  output  32  {sign, exponent[7:0], fraction[22:0]}
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero (exponent <= 0)

## Operation
- Internal registers: sign, 11-bit signed exponent, 27-bit mantissa, zero flag.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, latch inputs (in_exp sign-extended to 11 bits) -> NORM.
- NORM, in this priority order:
  - mant==0: set zero flag -> ROUND.
  - mant[26]=1: mant = mant>>1 with the shifted-out bit ORed into bit 0 (sticky), exp+1 -> ROUND.
  - mant[25]=1 -> ROUND.
  - Otherwise: mant<<1, exp-1, stay in NORM (at most 25 iterations).
- ROUND, round-to-nearest-even:
  - Increment at bit 2 when mant[1] & (mant[0] | mant[2]).
  - If the increment carries into bit 26: shift right 1, exp+1.
  - Classify, in this order:
    - zero flag: {sign, 31'b0}, flags 0.
    - exp >= 255: {sign, 8'hFF, 23'b0}, out_overflow=1.
    - exp <= 0: {sign, 31'b0}, out_underflow=1 (no denormals).
    - else: {sign, exp[7:0], mant[24:2]}.
  - Register out_result and flags -> DONE.
- DONE: out_valid=1. out_result and flags are held stable until out_valid & out_ready, then -> IDLE.
- No new input is accepted outside IDLE; the input side sees backpressure via in_ready=0.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, out_valid 0, out_result 32'h0, out_overflow 0, out_underflow 0, internal registers 0. in_ready is 1 while in IDLE.
- in_ready and out_valid are decoded from registered state only; there is no combinational in->out path.
- Latency from the accepting edge to out_valid high is 2 + L cycles, where L is the number of left shifts (0 for the carry, already-normalized and zero cases).
- The output handshake completes on the edge where out_valid & out_ready are both high. in_ready rises the following cycle.
- Minimum initiation interval is 4 + L cycles when out_ready is tied high.
- Reset asserted mid-operation: the word in flight is discarded, and no out_valid pulse follows.
- in_valid while not in IDLE is ignored. The source must hold the word until the handshake.

## Test plan
- Carry normalization: sign 0, in_exp 127, in_mant 27'h4000000 -> out_result 32'h40000000, flags 0, out_valid 2 cycles after accept.
- Left normalization: in_exp 127, in_mant 27'h0800000 -> two shifts, out_result 32'h3E800000, out_valid 4 cycles after accept.
- RNE ties: in_exp 127, in_mant 27'h2000002 -> 32'h3F800000 (tie to even, no increment). in_mant 27'h2000006 -> 32'h3F800002 (rounds up).
- Round-carry overflow: in_exp 254, in_mant 27'h3FFFFFE -> 32'h7F800000, out_overflow 1. The same input with sign 1 -> 32'hFF800000.
- Underflow and zero: in_exp 1, in_mant 27'h1000000 -> 32'h00000000, out_underflow 1. Sign 1, in_mant 0 -> 32'h80000000, flags 0.
- Backpressure and reset:
  - Hold out_ready 0 for 5 cycles in DONE: out_result stable and in_ready 0 throughout. Release: handshake, then in_ready 1 the next cycle.
  - Drop rst_n during NORM: out_valid 0 immediately, in_ready 1 after release, and no stale output appears.
